// File: rtl/usart_tx_scheduler.sv
// Round-robin byte scheduler for usart_tx: free-running bit-clock divider, one grant per frame plus gap.
// req_ready is combinational in IDLE (same-cycle accept); tx_enable/busy follow one clock later; requests wait while busy.
module usart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int HALF_BIT   = 5,
    parameter int FRAME_BITS = 10,
    parameter int GAP_BITS   = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       serial_clock,
    output logic [7:0]                 tx_data,
    output logic                       tx_enable,
    output logic                       busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int DW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(HALF_BIT - 1);
    localparam logic [3:0]    FRAME_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]    GAP_LAST   = 4'(GAP_BITS - 1);

    generate
        if (HALF_BIT < 1) begin : g_chk_half
            $error("HALF_BIT must be at least 1");
        end
        if (FRAME_BITS < 1 || FRAME_BITS > 15) begin : g_chk_frame
            $error("FRAME_BITS must be in 1..15");
        end
        if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_chk_gap
            $error("GAP_BITS must be in 0..15");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_req
            $error("NUM_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            sclk_q, sclk_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_enable_q, tx_enable_d;
    logic            busy_q, busy_d;

    logic            div_wrap;
    logic            sc_rise;
    logic [NUM_REQ-1:0] sel_oh;
    logic [GW-1:0]   sel_idx;
    logic [7:0]      sel_byte;
    logic            found;
    int              cand;

    // Divider runs regardless of state so the bit grid never shifts.
    always_comb begin
        div_wrap  = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        sclk_d    = sclk_q ^ div_wrap;
        sc_rise   = div_wrap & ~sclk_q;
    end

    // Search starts just above the last winner, wrapping, so each client waits at most NUM_REQ-1 frames.
    always_comb begin
        sel_oh   = '0;
        sel_idx  = '0;
        sel_byte = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (cand == i) && req_valid[i]) begin
                    found     = 1'b1;
                    sel_oh[i] = 1'b1;
                    sel_idx   = GW'(i);
                    sel_byte  = req_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = ((state_q == IDLE) && reset_n) ? sel_oh : '0;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_enable_d  = tx_enable_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    tx_data_d    = sel_byte;
                    grant_id_d   = sel_idx;
                    last_grant_d = sel_idx;
                    tx_enable_d  = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (sc_rise) begin
                    tx_enable_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (sc_rise) begin
                    if (bit_cnt_q == FRAME_LAST) begin
                        if (GAP_BITS == 0) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = GAP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (sc_rise) begin
                    if (bit_cnt_q == GAP_LAST) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            bit_cnt_q    <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sclk_q       <= sclk_d;
            bit_cnt_q    <= bit_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_enable_q  <= tx_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_clock = sclk_q;
    assign tx_data      = tx_data_q;
    assign tx_enable    = tx_enable_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_usart_tx_scheduler.sv
// Directed bench for usart_tx_scheduler: arbitration table plus timing, reset-abort, divider and zero-gap sequences.
module tb_usart_tx_scheduler;

    localparam int HB = 5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid, req_valid2;
    logic [31:0] req_data, req_data2;
    logic [3:0]  req_ready, req_ready2;
    logic [1:0]  grant_id, grant_id2;
    logic        serial_clock, serial_clock2;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_enable, tx_enable2;
    logic        busy, busy2;

    always #5 clock = ~clock;

    usart_tx_scheduler #(.NUM_REQ(4), .HALF_BIT(HB), .FRAME_BITS(10), .GAP_BITS(1)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .serial_clock(serial_clock),
        .tx_data(tx_data), .tx_enable(tx_enable), .busy(busy)
    );

    usart_tx_scheduler #(.NUM_REQ(4), .HALF_BIT(HB), .FRAME_BITS(10), .GAP_BITS(0)) dut_g0 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .grant_id(grant_id2), .serial_clock(serial_clock2),
        .tx_data(tx_data2), .tx_enable(tx_enable2), .busy(busy2)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] id;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [12];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n, h, l;
        // Round-robin pointer is 0 when the table starts (after the single-request sequence).
        vecs[0]  = '{4'b1111, 4'b0010, 2'd1, 8'h11};
        vecs[1]  = '{4'b1111, 4'b0100, 2'd2, 8'h12};
        vecs[2]  = '{4'b1111, 4'b1000, 2'd3, 8'h13};
        vecs[3]  = '{4'b1111, 4'b0001, 2'd0, 8'h10};
        vecs[4]  = '{4'b1111, 4'b0010, 2'd1, 8'h11};
        vecs[5]  = '{4'b1001, 4'b1000, 2'd3, 8'h13};
        vecs[6]  = '{4'b1001, 4'b0001, 2'd0, 8'h10};
        vecs[7]  = '{4'b0100, 4'b0100, 2'd2, 8'h12};
        vecs[8]  = '{4'b0011, 4'b0001, 2'd0, 8'h10};
        vecs[9]  = '{4'b0011, 4'b0010, 2'd1, 8'h11};
        vecs[10] = '{4'b1000, 4'b1000, 2'd3, 8'h13};
        vecs[11] = '{4'b0110, 4'b0010, 2'd1, 8'h11};

        reset_n    = 1'b0;
        req_valid  = 4'b1111;
        req_data   = 32'h0;
        req_valid2 = 4'b0000;
        req_data2  = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_sclk", serial_clock, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_enable", tx_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_req_ready", req_ready, 4'b0000);
        req_valid = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;

        // Single request, byte AA
        req_data[7:0] = 8'hAA;
        req_valid     = 4'b0001;
        #1;
        chk("s1_ready", req_ready, 4'b0001);
        @(negedge clock);
        req_valid = 4'b0000;
        chk("s1_tx_data", tx_data, 8'hAA);
        chk("s1_tx_enable", tx_enable, 1'b1);
        chk("s1_busy", busy, 1'b1);
        chk("s1_grant_id", grant_id, 2'd0);
        chk("s1_ready_one_cycle", req_ready, 4'b0000);
        c = 1;
        while (tx_enable && c <= 2*HB + 2) begin
            @(negedge clock);
            if (tx_enable) c++;
        end
        chk("s1_txen_len_max", (c <= 2*HB), 1'b1);
        chk("s1_sclk_at_txen_fall", serial_clock, 1'b1);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("s1_busy_after_txen", n, 110);
        chk("s1_hold_tx_data", tx_data, 8'hAA);
        chk("s1_hold_grant_id", grant_id, 2'd0);

        // Arbitration table
        req_data = 32'h13121110;
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            #1;
            c = 0;
            while (req_ready == 4'b0000 && c < 300) begin
                @(negedge clock);
                #1;
                c++;
            end
            if (c >= 300) begin
                tmo($sformatf("v%0d_ready", i));
            end else begin
                chk($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
                @(negedge clock);
                chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].data);
                chk($sformatf("v%0d_grant_id", i), grant_id, vecs[i].id);
                chk($sformatf("v%0d_tx_enable", i), tx_enable, 1'b1);
                chk($sformatf("v%0d_busy", i), busy, 1'b1);
                chk($sformatf("v%0d_ready_clear", i), req_ready, 4'b0000);
                c = 0;
                while (busy && c < 300) begin
                    @(negedge clock);
                    c++;
                end
                if (c >= 300) tmo($sformatf("v%0d_busy_fall", i));
            end
        end

        // Reset mid-SEND, then pending requester 1 re-granted
        req_valid = 4'b0010;
        #1;
        chk("rs_pre_ready", req_ready, 4'b0010);
        @(negedge clock);
        c = 0;
        while (tx_enable && c < 30) begin
            @(negedge clock);
            c++;
        end
        if (c >= 30) tmo("rs_txen_fall");
        repeat (45) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_sclk", serial_clock, 1'b0);
        chk("rs_tx_data", tx_data, 8'h00);
        chk("rs_tx_enable", tx_enable, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_grant_id", grant_id, 2'd0);
        chk("rs_req_ready", req_ready, 4'b0000);
        req_data[15:8] = 8'h77;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rs_post_ready", req_ready, 4'b0010);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                chk("rs_post_tx_data", tx_data, 8'h77);
                chk("rs_post_grant_id", grant_id, 2'd1);
                chk("rs_post_tx_enable", tx_enable, 1'b1);
                chk("rs_post_busy", busy, 1'b1);
                req_valid = 4'b0000;
            end
        end while (!serial_clock && n < 20);
        chk("rs_first_sclk_toggle", n, HB);

        // Divider: 50% duty, period 2*HB, during a frame then while idle
        for (int p = 0; p < 6; p++) begin
            h = 0;
            while (serial_clock && h < 20) begin
                @(negedge clock);
                h++;
            end
            l = 0;
            while (!serial_clock && l < 20) begin
                @(negedge clock);
                l++;
            end
            chk($sformatf("div_busy_high%0d", p), h, HB);
            chk($sformatf("div_busy_low%0d", p), l, HB);
        end
        c = 0;
        while (busy && c < 300) begin
            @(negedge clock);
            c++;
        end
        if (c >= 300) tmo("div_busy_fall");
        c = 0;
        while (serial_clock && c < 20) begin
            @(negedge clock);
            c++;
        end
        c = 0;
        while (!serial_clock && c < 20) begin
            @(negedge clock);
            c++;
        end
        for (int p = 0; p < 3; p++) begin
            h = 0;
            while (serial_clock && h < 20) begin
                @(negedge clock);
                h++;
            end
            l = 0;
            while (!serial_clock && l < 20) begin
                @(negedge clock);
                l++;
            end
            chk($sformatf("div_idle_high%0d", p), h, HB);
            chk($sformatf("div_idle_low%0d", p), l, HB);
        end
        chk("div_idle_busy", busy, 1'b0);

        // Zero-gap instance: back-to-back frames from requester 2
        req_data2[23:16] = 8'h5C;
        req_valid2       = 4'b0100;
        #1;
        chk("g0_ready", req_ready2, 4'b0100);
        @(negedge clock);
        chk("g0_tx_data", tx_data2, 8'h5C);
        chk("g0_tx_enable", tx_enable2, 1'b1);
        chk("g0_busy", busy2, 1'b1);
        c = 0;
        while (tx_enable2 && c < 30) begin
            @(negedge clock);
            c++;
        end
        if (c >= 30) tmo("g0_txen_fall");
        n = 0;
        while (busy2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("g0_frame_len", n, 100);
        chk("g0_ready_in_idle", req_ready2, 4'b0100);
        l = 0;
        while (!busy2 && l < 10) begin
            @(negedge clock);
            l++;
        end
        chk("g0_busy_low_cycles", l, 1);
        chk("g0_txen_reassert", tx_enable2, 1'b1);
        chk("g0_grant_id", grant_id2, 2'd2);
        req_valid2 = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
